// File: rtl/reg_pipe.sv
// reg_pipe: stallable, flushable DEPTH-stage delay line of WIDTH-bit words with
// per-stage valid bits and a registered occupancy count. Build option: REG_PIPE_RESET_DATA_EN.
module reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       d_valid,
    input  logic [WIDTH-1:0]           d,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Next-state: flush beats enable; a flush leaves the data registers untouched.
    always_comb begin
        s_d     = s_q;
        v_d     = v_q;
        count_d = count_q;
        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end else if (en) begin
            s_d[0] = d;
            v_d[0] = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
            // Stays within 0..DEPTH: an entry can only leave if it was counted.
            count_d = count_q + CW'(d_valid) - CW'(v_q[DEPTH-1]);
        end else begin
            s_d     = s_q;
            v_d     = v_q;
            count_d = count_q;
        end
    end

    // Control state: valid bits and occupancy, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

`ifdef REG_PIPE_RESET_DATA_EN
    // Data registers, cleared on reset in this build.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_q[i] <= '0;
            end
        end else begin
            s_q <= s_d;
        end
    end
`else
    // Data registers without reset; contents of invalid stages are don't-care.
    always_ff @(posedge clk) begin
        s_q <= s_d;
    end
`endif

    assign q       = s_q[DEPTH-1];
    assign q_valid = v_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised, stallable D-register pipeline: a `DEPTH`-stage delay line of `WIDTH`-bit words. Each stage carries a valid bit, and the block keeps an occupancy count. It generalises the single-bit D flip-flop into the standard delay and retiming element for datapath blocks. It adds per-stage valid tracking, stall (enable), flush, and a registered count of in-flight words.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 4, number of register stages (≥1); latency in enabled cycles
- `clk`  input  1  rising-edge clock; the only clock
- `reset`  input  1  synchronous, active-low reset (sampled on `clk` rising edge)
- `en`  input  1  advance pipeline this cycle; 0 = stall (hold all state)
- `flush`  input  1  invalidate all stages this cycle
- `d_valid`  input  1  `d` carries a valid word
- `d`  input  `WIDTH`  input word
- `q_valid`  output  1  valid bit of last stage
- `q`  output  `WIDTH`  data of last stage (stage `DEPTH-1`)
- `count`  output  `$clog2(DEPTH+1)`  number of valid stages, 0..`DEPTH`

## Operation
- State: data registers `s[0..DEPTH-1]`, valid bits `v[0..DEPTH-1]`, register `count`.
- Priority on each rising edge: reset (`reset`=0) > `flush` > `en` > hold.
- Reset: all `v`=0, `count`=0; data as defined under Configuration. Outputs after reset: `q_valid`=0, `count`=0.
- Flush: all `v`=0, `count`=0; data registers unchanged. Flush applies regardless of `en`. A `d_valid` word presented in a flush cycle is dropped.
- Enable, no flush:
  - `s[0]`←`d`, `v[0]`←`d_valid`
  - `s[i]`←`s[i-1]`, `v[i]`←`v[i-1]` for i≥1
  - `count`←`count` + `d_valid` − `v[DEPTH-1]`. The result is never outside 0..`DEPTH` and needs no saturation logic.
- Hold (`en`=0, no flush, no reset): every register keeps its value, including `count`. `d`/`d_valid` are ignored.
- Data of invalid stages is don't-care. It still shifts through, so `q` may show stale data while `q_valid`=0.
- `DEPTH`=1: single registered stage, `count` is 1 bit and equals `v[0]`.
- Invariant: `count` always equals popcount(`v`).

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency: a word accepted at enabled edge k appears on `q` with `q_valid`=1 after the `DEPTH`-th enabled edge counted from k inclusive. Stall cycles add latency one for one.
- Throughput: one word per enabled cycle.
- Reset mid-stream: in-flight words are discarded at that edge. The first edge with `reset`=1 behaves as a normal cycle.
- `flush` and `reset` asserted together: reset behaviour.

## Configuration
- `REG_PIPE_RESET_DATA_EN`
  - Defined: reset also clears every `s[i]` to 0, so `q`=0 after reset.
  - Undefined: data registers have no reset (smaller, no reset fan-out). `q` is X until `DEPTH` enabled cycles pass; only valid bits and `count` reset.
- Flush never clears data in either configuration.

## Test plan
- Reset then stream (WIDTH=8, DEPTH=4, `en`=1): drive `d`=0x11,0x22,0x33,0x44 with `d_valid`=1 on 4 consecutive edges. Required: `q`=0x11 with `q_valid`=1 after the 4th edge, then 0x22, 0x33, 0x44 on successive edges. `count` reads 1,2,3,4,4,…
- Stall: after 2 words are accepted, drop `en` for 3 cycles. Required: `q`, `q_valid` and `count`=2 frozen. `q`=0x11 arrives 3 cycles later than in the unstalled case.
- Bubbles: pattern `d_valid`=1,0,1,0 with `d`=0xA0..0xA3. Required: `q_valid`=1,0,1,0 after latency with `q`=0xA0, –, 0xA2, –. `count` never exceeds 2.
- Flush: fill to `count`=4, then assert `flush` and `d_valid`=1 with `en`=0 and `en`=1 in separate runs. Required: next edge `count`=0 and `q_valid`=0. The incoming word never appears. Refill resumes normal latency.
- Reset mid-stream: with `count`=3, pull `reset`=0 for one edge. Required: `count`=0 and `q_valid`=0. `q`=0 with `REG_PIPE_RESET_DATA_EN` defined; `q` not checked without it.
- `DEPTH`=1 build: `d`=0x5A, `d_valid`=1 → `q`=0x5A, `q_valid`=1, `count`=1 after one edge. Then `d_valid`=0 → `count`=0 on the next edge.
